// File: rtl/w5300_bus_engine_if.sv
// Request-side handshake between the driver logic and w5300_bus_engine.
// The driver (master) issues one access at a time. The engine (slave) answers
// with ready, a one-cycle done pulse and the captured read data.
interface w5300_bus_engine_if;
    logic        req;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [15:0] req_wdata;
    logic        ready;
    logic        done;
    logic [15:0] rdata;

    modport master (output req, req_we, req_addr, req_wdata,
                    input  ready, done, rdata);
    modport slave  (input  req, req_we, req_addr, req_wdata,
                    output ready, done, rdata);
endinterface

// File: rtl/w5300_bus_engine.sv
// Single-access engine for the W5300 16-bit direct parallel bus.
// It accepts one read or write over the req/ready handshake. It then walks
// SETUP -> STROBE -> HOLD -> RECOVER with cycle-counted phases, and it drives
// the data bus only while a write is in progress.
// Optional feature: define W5300_INT_SYNC_EN to synchronise and low-filter
// int_n. Otherwise irq is a plain inversion of int_n.
module w5300_bus_engine #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int RECOV_CYC  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    w5300_bus_engine_if.slave        bus,
    output logic [9:0]               addr,
    inout  wire  [15:0]              data,
    output logic                     cs_n,
    output logic                     rd_n,
    output logic                     we_n,
    output logic                     rw_n,
    input  logic                     int_n,
    output logic                     irq
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_STROBE  = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_RECOVER = 3'd4;

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] RECOV_LD  = 4'(RECOV_CYC - 1);

    logic [2:0]  state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [15:0] wdata_q;
    logic        data_oe;
    logic        done_q;
    logic [15:0] rdata_q;

    assign bus.ready = (state == ST_IDLE);
    assign bus.done  = done_q;
    assign bus.rdata = rdata_q;
    assign data      = data_oe ? wdata_q : 16'hzzzz;

    // Access sequencer: every pin is updated on the state transition edge, so no pin has a combinational path from req.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            wdata_q <= 16'h0000;
            addr    <= 10'h000;
            cs_n    <= 1'b1;
            rd_n    <= 1'b1;
            we_n    <= 1'b1;
            rw_n    <= 1'b1;
            data_oe <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 16'h0000;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        state   <= ST_SETUP;
                        cnt     <= SETUP_LD;
                        we_q    <= bus.req_we;
                        wdata_q <= bus.req_wdata;
                        addr    <= bus.req_addr;
                        cs_n    <= 1'b0;
                        rw_n    <= ~bus.req_we;
                        data_oe <= bus.req_we;
                    end
                end
                ST_SETUP: begin
                    if (cnt == 4'd0) begin
                        state <= ST_STROBE;
                        cnt   <= STROBE_LD;
                        rd_n  <= we_q;
                        we_n  <= ~we_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt == 4'd0) begin
                        state  <= ST_HOLD;
                        cnt    <= HOLD_LD;
                        rd_n   <= 1'b1;
                        we_n   <= 1'b1;
                        done_q <= 1'b1;
                        if (!we_q) begin
                            rdata_q <= data;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt == 4'd0) begin
                        state   <= ST_RECOVER;
                        cnt     <= RECOV_LD;
                        cs_n    <= 1'b1;
                        data_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RECOVER: begin
                    rw_n <= 1'b1;
                    if (cnt == 4'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef W5300_INT_SYNC_EN
    logic int_s1;
    logic int_s2;
    logic low_d;
    logic irq_q;

    // Two-flop synchroniser plus a two-sample low filter; irq drops as soon as the synchronised level returns high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_s1 <= 1'b1;
            int_s2 <= 1'b1;
            low_d  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            int_s1 <= int_n;
            int_s2 <= int_s1;
            low_d  <= ~int_s2;
            irq_q  <= low_d & ~int_s2;
        end
    end

    assign irq = irq_q & ~int_s2;
`else
    assign irq = ~int_n;
`endif

endmodule

// File: tb/tb_w5300_bus_engine.sv
// Self-checking bench for w5300_bus_engine.
// Instance A uses the default timing. Instance B uses the swept timing 2/1/3/1.
// Expected pin waveforms come from phase-window arithmetic, not from a copy of the FSM.
module tb_w5300_bus_engine;

    localparam int A_S = 1, A_T = 4, A_H = 1, A_R = 2;
    localparam int B_S = 2, B_T = 1, B_H = 3, B_R = 1;
    localparam logic [15:0] RESET_PINS = {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'h000};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic int_n = 1'b1;
    logic sel = 1'b0;
    logic t_req = 1'b0;
    logic t_we = 1'b0;
    logic [9:0] t_addr = 10'h000;
    logic [15:0] t_wdata = 16'h0000;
    logic [15:0] ext_val = 16'h0000;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_rd_a = 16'h0000;
    logic [15:0] last_rd_b = 16'h0000;

    w5300_bus_engine_if bus_a ();
    w5300_bus_engine_if bus_b ();

    logic [9:0]  addr_a, addr_b;
    wire  [15:0] data_a, data_b;
    logic cs_n_a, rd_n_a, we_n_a, rw_n_a, irq_a;
    logic cs_n_b, rd_n_b, we_n_b, rw_n_b, irq_b;

    assign bus_a.req       = t_req && !sel;
    assign bus_a.req_we    = t_we;
    assign bus_a.req_addr  = t_addr;
    assign bus_a.req_wdata = t_wdata;
    assign bus_b.req       = t_req && sel;
    assign bus_b.req_we    = t_we;
    assign bus_b.req_addr  = t_addr;
    assign bus_b.req_wdata = t_wdata;

    // W5300 read model: it drives the bus only while the read strobe is low.
    assign data_a = (!rd_n_a) ? ext_val : 16'hzzzz;
    assign data_b = (!rd_n_b) ? ext_val : 16'hzzzz;

    w5300_bus_engine dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .addr(addr_a), .data(data_a),
        .cs_n(cs_n_a), .rd_n(rd_n_a), .we_n(we_n_a), .rw_n(rw_n_a),
        .int_n(int_n), .irq(irq_a)
    );

    w5300_bus_engine #(.SETUP_CYC(B_S), .STROBE_CYC(B_T), .HOLD_CYC(B_H), .RECOV_CYC(B_R)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .addr(addr_b), .data(data_b),
        .cs_n(cs_n_b), .rd_n(rd_n_b), .we_n(we_n_b), .rw_n(rw_n_b),
        .int_n(int_n), .irq(irq_b)
    );

    logic [15:0] obs_pins;
    logic [15:0] obs_data;
    logic [15:0] obs_rdata;

    assign obs_pins  = sel ? {cs_n_b, rd_n_b, we_n_b, rw_n_b, bus_b.done, bus_b.ready, addr_b}
                           : {cs_n_a, rd_n_a, we_n_a, rw_n_a, bus_a.done, bus_a.ready, addr_a};
    assign obs_data  = sel ? data_b : data_a;
    assign obs_rdata = sel ? bus_b.rdata : bus_a.rdata;

    always #10 clk = ~clk;

    // Expected pins in cycle k after the accept edge, computed from the phase windows.
    function automatic logic [15:0] model_pins(input int k, input int s, input int t, input int h,
                                               input int r, input logic we, input logic [9:0] a);
        logic cs_on, strobe;
        cs_on  = (k >= 1) && (k <= s + t + h);
        strobe = (k > s) && (k <= s + t);
        return {~cs_on, ~(strobe && !we), ~(strobe && we), ~(we && (k <= s + t + h + 1)),
                (k == s + t + 1), (k > s + t + h + r), a};
    endfunction

    task automatic start_access(input logic which, input logic we, input logic [9:0] a,
                                input logic [15:0] wd, input logic [15:0] rv, input logic keep);
        sel     = which;
        t_we    = we;
        t_addr  = a;
        t_wdata = wd;
        ext_val = rv;
        t_req   = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) t_req = 1'b0;
    endtask

    task automatic test_reset;
        #25;
        for (int i = 0; i < 2; i++) begin
            sel = i[0];
            #1;
            checks++;
            if (obs_pins !== RESET_PINS) begin
                errors++;
                $display("[TB] FAIL reset_pins dut=%0d got %h want %h", i, obs_pins, RESET_PINS);
            end
            checks++;
            if (obs_rdata !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL reset_rdata dut=%0d got %h want 0000", i, obs_rdata);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sel = 1'b0;
        #1;
        checks++;
        if (obs_pins !== RESET_PINS) begin
            errors++;
            $display("[TB] FAIL idle_after_reset got %h want %h", obs_pins, RESET_PINS);
        end
        @(negedge clk);
    endtask

    task automatic test_accesses(input logic which, input int nrand, input string tag);
        int s, t, h, r, len;
        logic we;
        logic [9:0] a;
        logic [15:0] wd, rv, prev, exp_rd, exp_p;
        logic drive, ext;
        s = which ? B_S : A_S;
        t = which ? B_T : A_T;
        h = which ? B_H : A_H;
        r = which ? B_R : A_R;
        len = s + t + h + r;
        for (int n = 0; n < nrand + 2; n++) begin
            if (n == 0) begin
                we = 1'b1; a = 10'h200; wd = 16'hA55A; rv = 16'h0F0F;
            end else if (n == 1) begin
                we = 1'b0; a = 10'h0FE; wd = 16'h5AA5; rv = 16'h1234;
            end else begin
                we = 1'($urandom_range(0, 1));
                a  = 10'($urandom);
                rv = 16'($urandom);
                wd = 16'($urandom) | 16'h0001;
                if (wd == rv) wd = wd ^ 16'h0002;
            end
            prev = which ? last_rd_b : last_rd_a;
            start_access(which, we, a, wd, rv, 1'b0);
            for (int k = 1; k <= len + 1; k++) begin
                @(negedge clk);
                exp_p = model_pins(k, s, t, h, r, we, a);
                checks++;
                if (obs_pins !== exp_p) begin
                    errors++;
                    $display("[TB] FAIL %s_pins n=%0d k=%0d got %h want %h", tag, n, k, obs_pins, exp_p);
                end
                drive = we && (k <= s + t + h);
                ext   = !we && (k > s) && (k <= s + t);
                checks++;
                if ((drive && obs_data !== wd) || (ext && obs_data !== rv) ||
                    (!drive && !ext && obs_data === wd)) begin
                    errors++;
                    $display("[TB] FAIL %s_data n=%0d k=%0d got %h wdata %h rdval %h", tag, n, k, obs_data, wd, rv);
                end
                exp_rd = (!we && k >= s + t + 1) ? rv : prev;
                checks++;
                if (obs_rdata !== exp_rd) begin
                    errors++;
                    $display("[TB] FAIL %s_rdata n=%0d k=%0d got %h want %h", tag, n, k, obs_rdata, exp_rd);
                end
            end
            if (!we) begin
                if (which) last_rd_b = rv;
                else last_rd_a = rv;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_p;
        start_access(1'b0, 1'b1, 10'h2A5, 16'h1357, 16'h2468, 1'b1);
        t_we = 1'b0;
        t_addr = 10'h0C3;
        t_wdata = 16'h9BDF;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_p = model_pins(k, A_S, A_T, A_H, A_R, 1'b1, 10'h2A5);
            checks++;
            if (obs_pins !== exp_p) begin
                errors++;
                $display("[TB] FAIL b2b_first k=%0d got %h want %h", k, obs_pins, exp_p);
            end
        end
        @(posedge clk);
        #1;
        t_req = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_p = model_pins(k, A_S, A_T, A_H, A_R, 1'b0, 10'h0C3);
            checks++;
            if (obs_pins !== exp_p) begin
                errors++;
                $display("[TB] FAIL b2b_second k=%0d got %h want %h", k, obs_pins, exp_p);
            end
        end
        checks++;
        if (obs_rdata !== 16'h2468) begin
            errors++;
            $display("[TB] FAIL b2b_rdata got %h want 2468", obs_rdata);
        end
        last_rd_a = 16'h2468;
    endtask

    task automatic test_busy_ignore;
        logic [15:0] exp_p;
        int done_cnt;
        done_cnt = 0;
        start_access(1'b0, 1'b1, 10'h3C3, 16'h7E81, 16'h0000, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_p = model_pins(k, A_S, A_T, A_H, A_R, 1'b1, 10'h3C3);
            checks++;
            if (obs_pins !== exp_p) begin
                errors++;
                $display("[TB] FAIL busy_pins k=%0d got %h want %h", k, obs_pins, exp_p);
            end
            if (k <= A_S + A_T + A_H) begin
                checks++;
                if (obs_data !== 16'h7E81) begin
                    errors++;
                    $display("[TB] FAIL busy_data k=%0d got %h want 7e81", k, obs_data);
                end
            end
            if (obs_pins[11] === 1'b1) done_cnt++;
            if (k == 3) begin
                t_req = 1'b1; t_we = 1'b0; t_addr = 10'h011; t_wdata = 16'h0F0F;
            end
            if (k == 4) t_req = 1'b0;
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("[TB] FAIL busy_done_count got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_reset_mid;
        int done_cnt;
        done_cnt = 0;
        start_access(1'b0, 1'b1, 10'h155, 16'hC33C, 16'h0000, 1'b0);
        for (int k = 1; k <= 3; k++) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_pins !== RESET_PINS) begin
            errors++;
            $display("[TB] FAIL abort_pins got %h want %h", obs_pins, RESET_PINS);
        end
        checks++;
        if (obs_data === 16'hC33C) begin
            errors++;
            $display("[TB] FAIL abort_data still driven got %h want released", obs_data);
        end
        last_rd_a = 16'h0000;
        last_rd_b = 16'h0000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (obs_pins[11] === 1'b1) done_cnt++;
            checks++;
            if (obs_pins !== RESET_PINS) begin
                errors++;
                $display("[TB] FAIL abort_idle k=%0d got %h want %h", k, obs_pins, RESET_PINS);
            end
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("[TB] FAIL abort_done_count got %0d want 0", done_cnt);
        end
    endtask

    task automatic test_irq;
`ifdef W5300_INT_SYNC_EN
        int lens [3];
        logic exp_irq;
        lens[0] = 1;
        lens[1] = 5;
        lens[2] = $urandom_range(3, 6);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            int_n = 1'b0;
            for (int n = 1; n <= lens[i] + 5; n++) begin
                @(negedge clk);
                exp_irq = (n >= 4) && (n <= lens[i] + 1);
                checks++;
                if (irq_a !== exp_irq) begin
                    errors++;
                    $display("[TB] FAIL irq_sync len=%0d n=%0d got %b want %b", lens[i], n, irq_a, exp_irq);
                end
                if (n == lens[i]) int_n = 1'b1;
            end
        end
`else
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            int_n = (i < 2) ? i[0] : 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (irq_a !== ~int_n) begin
                errors++;
                $display("[TB] FAIL irq_pass int_n=%b got %b want %b", int_n, irq_a, ~int_n);
            end
        end
        int_n = 1'b1;
`endif
    endtask

    initial begin
        test_reset();
        test_accesses(1'b0, 6, "default");
        test_back_to_back();
        test_busy_ignore();
        test_accesses(1'b1, 4, "sweep");
        sel = 1'b0;
        test_reset_mid();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
